event_indicator: RTL

EVENT_INDICATOR -- requirements
Module: event_indicator

---
 rtl/event_indicator_pkg.sv | 12 +
 rtl/phase_timer.sv | 35 +++
 rtl/event_indicator.sv | 139 +++++++++++++
 3 files changed

// File: rtl/event_indicator_pkg.sv
// Shared types and constants for the event_indicator blink sequencer.
package event_indicator_pkg;

    localparam int BLINK_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_e;

endpackage

// File: rtl/phase_timer.sv
// Saturating phase counter: load clears, count advances up to the limit.
module phase_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         count_i,
    input  logic [W-1:0] limit_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o = (cnt_q == limit_i);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (count_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/event_indicator.sv
// Blink sequencer: N x (ON_CYCLES high, OFF_CYCLES low) per request.
// Define EVENT_INDICATOR_QUEUE_EN to add a one-deep pending request slot.
module event_indicator
    import event_indicator_pkg::*;
#(
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 25000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic [BLINK_W-1:0] blinks,
    output logic               ready,
    output logic               busy,
    output logic               led,
    output logic               done
);

    localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_e             state_q;
    logic [BLINK_W-1:0] rem_q;
    logic               led_q;
    logic               busy_q;
    logic               done_q;

    logic [CW-1:0] lim;
    logic          tc;
    logic          tmr_load;
    logic          tmr_count;
    logic          take;

    assign take = req && ready && (blinks != '0);

`ifdef EVENT_INDICATOR_QUEUE_EN
    logic [BLINK_W-1:0] slot_q;
    logic               slot_full_q;
    logic               last;

    assign last  = (state_q == OFF) && tc && (rem_q == BLINK_W'(1));
    assign ready = reset && ((state_q == IDLE) || !slot_full_q);
`else
    assign ready = reset && (state_q == IDLE);
`endif

    assign lim = (state_q == OFF) ? CW'(OFF_CYCLES - 1) : CW'(ON_CYCLES - 1);

    // Counter is held at zero in IDLE and reloaded at every phase change.
    assign tmr_load  = (state_q == IDLE) || tc;
    assign tmr_count = (state_q != IDLE);

    phase_timer #(
        .W(CW)
    ) u_timer (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (tmr_load),
        .count_i(tmr_count),
        .limit_i(lim),
        .tc_o   (tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            led_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef EVENT_INDICATOR_QUEUE_EN
            slot_q      <= '0;
            slot_full_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (take) begin
                        state_q <= ON;
                        led_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        rem_q   <= blinks;
                    end
                end
                ON: begin
                    if (tc) begin
                        state_q <= OFF;
                        led_q   <= 1'b0;
                    end
                end
                OFF: begin
                    if (tc && (rem_q != BLINK_W'(1))) begin
                        rem_q   <= rem_q - 1'b1;
                        state_q <= ON;
                        led_q   <= 1'b1;
                    end else if (tc) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        rem_q   <= '0;
`ifdef EVENT_INDICATOR_QUEUE_EN
                        // Chain straight into the pending or arriving request.
                        if (slot_full_q) begin
                            state_q     <= ON;
                            led_q       <= 1'b1;
                            busy_q      <= 1'b1;
                            rem_q       <= slot_q;
                            slot_q      <= '0;
                            slot_full_q <= 1'b0;
                        end else if (take) begin
                            state_q <= ON;
                            led_q   <= 1'b1;
                            busy_q  <= 1'b1;
                            rem_q   <= blinks;
                        end
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    led_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
`ifdef EVENT_INDICATOR_QUEUE_EN
            if (take && (state_q != IDLE) && !last) begin
                slot_q      <= blinks;
                slot_full_q <= 1'b1;
            end
`endif
        end
    end

    assign busy = busy_q;
    assign led  = led_q;
    assign done = done_q;

endmodule
